// File: rtl/ti_pkg.sv
// Shared constants and FSM state type for the threshold-implementation
// nibble serializer.
package ti_pkg;

  localparam int NIB_DEF = 16;
  localparam int NIB_W   = 4;
  localparam int SHARES  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ti_vld_delay.sv
// Valid/index delay line that mirrors the latency of the external share-wise
// stage, so each returning nibble is tagged with the position it came from.
module ti_vld_delay #(
  parameter int DEPTH = 0,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign out_vld = in_vld;
    assign out_idx = in_idx;
  end else begin : g_pipe
    logic [IDX_W:0] stage_q [DEPTH];
    logic [IDX_W:0] stage_d [DEPTH];

    // NOTE: every output of an always_comb must be assigned on every path,
    // otherwise synthesis infers a latch; here each element is always written.
    always_comb begin
      stage_d[0] = {in_vld, in_idx};
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value and the shift happens in parallel.
    // NOTE: this small array is reset (unlike a RAM) because a stale valid
    // surviving reset would write a phantom nibble into the results.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign {out_vld, out_idx} = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/ti_nibble_serializer.sv
// Nibble-serial sequencer for a 3-share state: issues one nibble per share per
// cycle to an external TI stage and reassembles the returned nibble shares.
module ti_nibble_serializer
  import ti_pkg::*;
#(
  parameter int NIB       = NIB_DEF,
  parameter int STAGE_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NIB_W*NIB-1:0] x1,
  input  logic [NIB_W*NIB-1:0] x2,
  input  logic [NIB_W*NIB-1:0] x3,
  output logic                 busy,
  output logic                 done,
  output logic [NIB_W*NIB-1:0] y1,
  output logic [NIB_W*NIB-1:0] y2,
  output logic [NIB_W*NIB-1:0] y3,
  output logic [NIB_W-1:0]     sb_x1,
  output logic [NIB_W-1:0]     sb_x2,
  output logic [NIB_W-1:0]     sb_x3,
  output logic                 sb_vld,
  input  logic [NIB_W-1:0]     sb_y1,
  input  logic [NIB_W-1:0]     sb_y2,
  input  logic [NIB_W-1:0]     sb_y3
);

  localparam int W     = NIB_W * NIB;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = $clog2(NIB + 1);
  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [IDX_W-1:0] cap_q, cap_d;
  logic [IDX_W-1:0] issue_idx;
  logic [W-1:0]     s_q [SHARES];
  logic [W-1:0]     s_d [SHARES];
  logic [W-1:0]     y_q [SHARES];
  logic [W-1:0]     y_d [SHARES];
  logic [W-1:0]     x_in [SHARES];
  logic [NIB_W-1:0] sb_y_in [SHARES];
  logic [NIB_W-1:0] sb_x_out [SHARES];
  logic             dly_vld;
  logic [IDX_W-1:0] dly_idx;

  assign x_in    = '{x1, x2, x3};
  assign sb_y_in = '{sb_y1, sb_y2, sb_y3};
  assign issue_idx = issue_q[IDX_W-1:0];

  ti_vld_delay #(
    .DEPTH (STAGE_LAT),
    .IDX_W (IDX_W)
  ) u_vld_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (sb_vld),
    .in_idx  (issue_idx),
    .out_vld (dly_vld),
    .out_idx (dly_idx)
  );

  // Each share is sliced and written on its own; shares never meet in logic.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    s_d     = s_q;
    y_d     = y_q;
    sb_vld  = 1'b0;
    for (int j = 0; j < SHARES; j++) begin
      sb_x_out[j] = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = x_in;
          issue_d = '0;
          cap_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_q < ISSUE_END) begin
          sb_vld  = 1'b1;
          issue_d = issue_q + 1'b1;
          for (int j = 0; j < SHARES; j++) begin
            sb_x_out[j] = s_q[j][{issue_idx, 2'b00} +: NIB_W];
          end
        end
        if (dly_vld) begin
          for (int j = 0; j < SHARES; j++) begin
            y_d[j][{cap_q, 2'b00} +: NIB_W] = sb_y_in[j];
          end
          if (dly_idx == LAST_IDX) state_d = ST_DONE;
          else                     cap_d   = cap_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      issue_q <= '0;
      cap_q   <= '0;
      for (int j = 0; j < SHARES; j++) begin
        s_q[j] <= '0;
        y_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
      s_q     <= s_d;
      y_q     <= y_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign y1    = y_q[0];
  assign y2    = y_q[1];
  assign y3    = y_q[2];
  assign sb_x1 = sb_x_out[0];
  assign sb_x2 = sb_x_out[1];
  assign sb_x3 = sb_x_out[2];

endmodule

// File: tb/tb_ti_nibble_serializer.sv
// Bench: one combinational-stage instance (LAT=0) and one two-flop-stage
// instance (LAT=2), each checked against a nibble-wise reference model.
module tb_ti_nibble_serializer;

  localparam int NIB = 16;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             vld;
    logic [2:0][3:0]  sbx;
    logic [2:0][63:0] y;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [63:0] x1 = '0, x2 = '0, x3 = '0;
  int          mode = 0;
  int          errors = 0;
  int          checks = 0;

  logic        busy_a, done_a, vld_a, busy_b, done_b, vld_b;
  logic [63:0] y1_a, y2_a, y3_a, y1_b, y2_b, y3_b;
  logic [3:0]  sbx1_a, sbx2_a, sbx3_a, sby1_a, sby2_a, sby3_a;
  logic [3:0]  sbx1_b, sbx2_b, sbx3_b, sby1_b, sby2_b, sby3_b;
  logic [3:0]  p1_b [3];
  logic [3:0]  p2_b [3];
  obs_t        obs_a, obs_b;

  always #5 clk = ~clk;

  // Reference share-wise stage: identity, nibble increment, or affine map.
  function automatic logic [3:0] stage_f(input int md, input int j, input logic [3:0] n);
    int t;
    case (md)
      0:       t = int'(n);
      1:       t = int'(n) + 1;
      default: t = int'(n) * 3 + j + 5;
    endcase
    return 4'(t);
  endfunction

  function automatic logic [63:0] ref_y(input int md, input int j, input logic [63:0] xv);
    logic [63:0] r;
    for (int n = 0; n < NIB; n++) r[4*n +: 4] = stage_f(md, j, xv[4*n +: 4]);
    return r;
  endfunction

  assign sby1_a = stage_f(mode, 0, sbx1_a);
  assign sby2_a = stage_f(mode, 1, sbx2_a);
  assign sby3_a = stage_f(mode, 2, sbx3_a);

  always @(posedge clk) begin
    p1_b[0] <= stage_f(mode, 0, sbx1_b);
    p1_b[1] <= stage_f(mode, 1, sbx2_b);
    p1_b[2] <= stage_f(mode, 2, sbx3_b);
    p2_b    <= p1_b;
  end
  assign sby1_b = p2_b[0];
  assign sby2_b = p2_b[1];
  assign sby3_b = p2_b[2];

  ti_nibble_serializer #(.NIB(NIB), .STAGE_LAT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_a), .done(done_a), .y1(y1_a), .y2(y2_a), .y3(y3_a),
    .sb_x1(sbx1_a), .sb_x2(sbx2_a), .sb_x3(sbx3_a), .sb_vld(vld_a),
    .sb_y1(sby1_a), .sb_y2(sby2_a), .sb_y3(sby3_a)
  );

  ti_nibble_serializer #(.NIB(NIB), .STAGE_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_b), .done(done_b), .y1(y1_b), .y2(y2_b), .y3(y3_b),
    .sb_x1(sbx1_b), .sb_x2(sbx2_b), .sb_x3(sbx3_b), .sb_vld(vld_b),
    .sb_y1(sby1_b), .sb_y2(sby2_b), .sb_y3(sby3_b)
  );

  assign obs_a = {busy_a, done_a, vld_a, sbx3_a, sbx2_a, sbx1_a, y3_a, y2_a, y1_a};
  assign obs_b = {busy_b, done_b, vld_b, sbx3_b, sbx2_b, sbx1_b, y3_b, y2_b, y1_b};

  task automatic set_start(input int d, input logic v);
    if (d == 0) start_a = v;
    else        start_b = v;
  endtask

  task automatic launch(input int d, input logic [63:0] xv [3]);
    @(negedge clk);
    x1 = xv[0]; x2 = xv[1]; x3 = xv[2];
    set_start(d, 1'b1);
    @(posedge clk);
  endtask

  // Called just after the start edge; walks the whole pass plus one idle cycle.
  task automatic check_pass(input int d, input logic [63:0] xv [3], input string tag,
                            input bit hold, input int poke, input logic [63:0] pv [3]);
    int          lat;
    obs_t        o;
    logic [63:0] ey [3];
    logic [2:0]  exp_ctl;
    logic [3:0]  exp_nib;
    lat = (d == 0) ? 0 : 2;
    for (int j = 0; j < 3; j++) ey[j] = ref_y(mode, j, xv[j]);
    for (int c = 1; c <= NIB + lat + 2; c++) begin
      @(negedge clk);
      o = (d == 0) ? obs_a : obs_b;
      exp_ctl = {c <= NIB + lat, c == NIB + lat + 1, c <= NIB};
      checks++;
      if ({o.busy, o.done, o.vld} !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl cycle=%0d busy/done/vld got=%b required=%b",
                 tag, c, {o.busy, o.done, o.vld}, exp_ctl);
      end
      for (int j = 0; j < 3; j++) begin
        exp_nib = '0;
        if (c <= NIB) exp_nib = xv[j][4*(c-1) +: 4];
        checks++;
        if (o.sbx[j] !== exp_nib) begin
          errors++;
          $display("FAIL %s sb_x%0d cycle=%0d got=%h required=%h", tag, j+1, c, o.sbx[j], exp_nib);
        end
        if (c >= NIB + lat + 1) begin
          checks++;
          if (o.y[j] !== ey[j]) begin
            errors++;
            $display("FAIL %s y%0d cycle=%0d got=%h required=%h", tag, j+1, c, o.y[j], ey[j]);
          end
        end
      end
      if (c == poke) begin
        x1 = pv[0]; x2 = pv[1]; x3 = pv[2];
        set_start(d, 1'b1);
      end else begin
        set_start(d, hold);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (obs_a !== '0) begin
      errors++;
      $display("FAIL %s lat0 outputs got=%h required=0", tag, obs_a);
    end
    checks++;
    if (obs_b !== '0) begin
      errors++;
      $display("FAIL %s lat2 outputs got=%h required=0", tag, obs_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_identity_lat0();
    logic [63:0] xv [3];
    mode = 0;
    xv = '{64'h0123456789ABCDEF, ~64'h0123456789ABCDEF, 64'h0};
    launch(0, xv);
    check_pass(0, xv, "identity_lat0", 1'b0, 0, xv);
  endtask

  task automatic test_loopback_lat2();
    logic [63:0] xv [3];
    mode = 0;
    xv = '{64'hFEDCBA9876543210, {$urandom, $urandom}, {$urandom, $urandom}};
    launch(1, xv);
    check_pass(1, xv, "loopback_lat2", 1'b0, 0, xv);
  endtask

  task automatic test_increment();
    logic [63:0] xv [3];
    mode = 1;
    xv = '{64'h0, 64'hFFFFFFFFFFFFFFFF, {$urandom, $urandom}};
    launch(0, xv);
    check_pass(0, xv, "increment", 1'b0, 0, xv);
    checks++;
    if (y1_a !== 64'h1111111111111111) begin
      errors++;
      $display("FAIL increment_y1_const got=%h required=1111111111111111", y1_a);
    end
    checks++;
    if (y2_a !== 64'h0) begin
      errors++;
      $display("FAIL increment_y2_const got=%h required=0", y2_a);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] xv [3];
    logic [63:0] pv [3];
    mode = 2;
    xv = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    pv = '{~xv[0], ~xv[1], xv[2] ^ 64'h5A5A5A5A5A5A5A5A};
    launch(0, xv);
    check_pass(0, xv, "start_ignored", 1'b0, 5, pv);
  endtask

  task automatic test_reset_mid_pass();
    logic [63:0] xv [3];
    mode = 2;
    xv = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    launch(1, xv);
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      start_b = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_pass_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_zero("reset_mid_pass_drain");
    end
    xv = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    launch(1, xv);
    check_pass(1, xv, "after_reset", 1'b0, 0, xv);
  endtask

  task automatic test_back_to_back();
    logic [63:0] av [3];
    logic [63:0] bv [3];
    mode = 2;
    av = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    bv = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    launch(0, av);
    check_pass(0, av, "b2b_first", 1'b1, 3, bv);
    @(posedge clk);
    check_pass(0, bv, "b2b_second", 1'b0, 0, bv);
  endtask

  task automatic test_random();
    logic [63:0] xv [3];
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      xv = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
      launch(r % 2, xv);
      check_pass(r % 2, xv, "random", 1'b0, 0, xv);
    end
  endtask

  initial begin
    test_reset();
    test_identity_lat0();
    test_loopback_lat2();
    test_increment();
    test_start_ignored();
    test_reset_mid_pass();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
